flush_nibble_drain: RTL and testbench
=====================================

FLUSH_NIBBLE_DRAIN -- requirements
Module: flush_nibble_drain

Interface
REQ-001: Parameter PAD_NIBBLE, default 4'hC, is the padding value that marks unused nibble slots in a flushed word.
REQ-002: Parameter NIBBLES, default 8, is the number of 4-bit slots per flushed word; the word width is 4*NIBBLES.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: reset  input  1  asynchronous, active-low reset; low forces reset state immediately, independent of clk.
REQ-005: flush_word_i  input  32  flushed FIFO word; slot k is [4k+3:4k], slot 0 is the oldest entry, unused slots hold PAD_NIBBLE.
REQ-006: flush_done_i  input  1  one-cycle strobe; flush_word_i is valid in this cycle.
REQ-007: out_ready_i  input  1  downstream ready for a nibble.
REQ-008: out_valid_o  output  1  out_data_o holds a valid nibble.
REQ-009: out_data_o  output  4  current nibble.
REQ-010: out_last_o  output  1  current nibble is the final nibble of its word; qualified by out_valid_o.
REQ-011: busy_o  output  1  a word is captured and not fully drained.
REQ-012: word_len_o  output  4  valid-nibble count (0..8) of the most recently captured word.
REQ-013: empty_word_o  output  1  one-cycle pulse when a captured word has length 0.
REQ-014: overrun_o  output  1  sticky flag: a word was dropped because the block was busy.

Function
REQ-015: State machine: IDLE and SEND only.
REQ-016: Length = NIBBLES minus the number of consecutive PAD_NIBBLE slots counted downward from slot 7.
- A PAD_NIBBLE value in the topmost data slots is treated as padding and is dropped.
- PAD_NIBBLE values below the highest non-pad slot are emitted as data.
REQ-017: In IDLE, a rising edge with flush_done_i=1 captures flush_word_i and loads word_len_o.
- Length > 0: go to SEND with slot index 0.
- Length = 0: stay in IDLE and pulse empty_word_o in the next cycle.
REQ-018: Latency: when flush_done_i is sampled at edge N, out_valid_o is high, showing slot 0, from edge N until the first handshake.
REQ-019: A handshake occurs at a rising edge where out_valid_o=1 and out_ready_i=1; each handshake advances the slot index by 1.
REQ-020: While out_valid_o=1 and out_ready_i=0, out_data_o, out_last_o and the slot index hold stable.
REQ-021: out_valid_o SHALL NOT depend combinationally on out_ready_i.
REQ-022: out_last_o=1 exactly when slot index = word_len_o-1.
- A handshake on the last nibble returns the block to IDLE and drives out_valid_o low in the following cycle.
REQ-023: flush_done_i coincident with the last-nibble handshake is accepted as in IDLE (back-to-back words, no bubble).
REQ-024: flush_done_i in SEND at any other time:
- the incoming word is dropped and overrun_o is set to 1;
- the word being drained continues unaffected.
REQ-025: overrun_o clears only on reset.
REQ-026: busy_o = 1 exactly in SEND.
REQ-027: The slot index is 3 bits wide and never wraps past word_len_o-1.
REQ-028: out_data_o = 0 whenever out_valid_o = 0.

Reset
REQ-029: While reset=0:
- state = IDLE, slot index = 0, captured word = 0;
- out_valid_o=0, out_data_o=0, out_last_o=0, busy_o=0, word_len_o=0, empty_word_o=0, overrun_o=0.
REQ-030: Reset asserted mid-SEND discards the partial word; no further nibbles of that word are emitted after reset releases.
REQ-031: The first flush_done_i is honoured at the first rising edge after reset goes high.

Verification
REQ-032: Full word 0x87654321, flush_done 1 cycle, out_ready held 1.
- -> nibbles 1,2,3,4,5,6,7,8 on 8 consecutive cycles; out_last only on 8; word_len_o=8; busy_o low after.
REQ-033: Word 0xCCCCC5A3, out_ready toggling 1/0.
- -> nibbles 3,A,5 only; each held stable through ready=0 cycles; word_len_o=3; out_last on 5.
REQ-034: Word 0xCCCCCCCC.
- -> no out_valid_o; empty_word_o high exactly one cycle; word_len_o=0; busy_o stays 0.
REQ-035: Word 0xCCCCCC21 drained with ready=1, second word 0xCCCCCC43 strobed on the last-nibble handshake.
- -> stream 1,2,3,4 with no idle cycle; overrun_o stays 0.
REQ-036: Second strobe (0x99999999) during a drain of 0xCCCC4321 with ready=0.
- -> overrun_o=1 and stays 1; output continues 1,2,3,4; no 9 emitted.
REQ-037: Reset pulled low asynchronously after 2 of 8 nibbles are accepted.
- -> all outputs 0 immediately; after release, no nibbles until a new flush_done_i.

Source files
------------

// File: rtl/flush_nibble_drain.sv
// Drains a flushed FIFO word one nibble at a time through a valid/ready port.
// Top-of-word PAD_NIBBLE slots are trimmed. A word that arrives while busy is dropped and flagged.
module flush_nibble_drain #(
    parameter logic [3:0] PAD_NIBBLE = 4'hC,
    parameter int         NIBBLES    = 8,
    localparam int        W          = 4 * NIBBLES,
    localparam int        LEN_W      = $clog2(NIBBLES + 1),
    localparam int        IDX_W      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     flush_word_i,
    input  logic             flush_done_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [3:0]       out_data_o,
    output logic             out_last_o,
    output logic             busy_o,
    output logic [LEN_W-1:0] word_len_o,
    output logic             empty_word_o,
    output logic             overrun_o
);

    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       word_q, word_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               valid_q, valid_d;
    logic [3:0]         data_q, data_d;
    logic               last_q, last_d;
    logic               empty_q, empty_d;
    logic               ovr_q, ovr_d;

    logic               hs_s, drain_end_s, accept_s;
    logic [LEN_W-1:0]   cap_len_s;

    // Count pad slots downward from the top slot; the first non-pad slot stops the trim.
    function automatic logic [LEN_W-1:0] calc_len(input logic [W-1:0] w);
        logic [LEN_W-1:0] n;
        logic             stop;
        n    = LEN_W'(NIBBLES);
        stop = 1'b0;
        for (int k = NIBBLES - 1; k >= 0; k--) begin
            if (!stop && (w[4*k +: 4] == PAD_NIBBLE)) begin
                n = n - LEN_W'(1);
            end else begin
                stop = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [3:0] nibble_at(input logic [W-1:0] w, input logic [IDX_W-1:0] idx);
        logic [3:0] r;
        r = 4'h0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (idx == IDX_W'(k)) begin
                r = w[4*k +: 4];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    assign hs_s        = valid_q && out_ready_i;
    assign drain_end_s = hs_s && last_q;
    assign accept_s    = flush_done_i && ((state_q == IDLE) || drain_end_s);
    assign cap_len_s   = calc_len(flush_word_i);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a capture on the final handshake chains words with no bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s && (cap_len_s != LEN_W'(0))) state_d = SEND;
                else                                      state_d = IDLE;
            end
            SEND: begin
                if (accept_s && (cap_len_s != LEN_W'(0))) state_d = SEND;
                else if (drain_end_s)                     state_d = IDLE;
                else                                      state_d = SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values, derived from the next state so outputs are registered.
    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        len_d   = len_q;
        empty_d = 1'b0;
        ovr_d   = ovr_q;
        if (accept_s) begin
            word_d  = flush_word_i;
            len_d   = cap_len_s;
            idx_d   = IDX_W'(0);
            empty_d = (cap_len_s == LEN_W'(0));
        end else if (hs_s) begin
            if (last_q) idx_d = IDX_W'(0);
            else        idx_d = idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end
        if (flush_done_i && (state_q == SEND) && !drain_end_s) begin
            ovr_d = 1'b1;
        end else begin
            ovr_d = ovr_q;
        end
        valid_d = (state_d == SEND);
        data_d  = valid_d ? nibble_at(word_d, idx_d) : 4'h0;
        last_d  = valid_d && (LEN_W'(idx_d) == (len_d - LEN_W'(1)));
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 4'h0;
            last_q  <= 1'b0;
            empty_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            empty_q <= empty_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_valid_o  = valid_q;
    assign out_data_o   = data_q;
    assign out_last_o   = last_q;
    assign busy_o       = (state_q == SEND);
    assign word_len_o   = len_q;
    assign empty_word_o = empty_q;
    assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_flush_nibble_drain.sv
// Directed table-driven bench for flush_nibble_drain, plus hand sequences for
// async reset mid-drain and ready-independence of out_valid_o.
module tb_flush_nibble_drain;

    logic        clk;
    logic        reset;
    logic [31:0] flush_word_i;
    logic        flush_done_i;
    logic        out_ready_i;
    logic        out_valid_o;
    logic [3:0]  out_data_o;
    logic        out_last_o;
    logic        busy_o;
    logic [3:0]  word_len_o;
    logic        empty_word_o;
    logic        overrun_o;

    int errors = 0;
    int checks = 0;

    flush_nibble_drain dut (
        .clk          (clk),
        .reset        (reset),
        .flush_word_i (flush_word_i),
        .flush_done_i (flush_done_i),
        .out_ready_i  (out_ready_i),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o),
        .word_len_o   (word_len_o),
        .empty_word_o (empty_word_o),
        .overrun_o    (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {valid, data, last, busy, len, empty, overrun}
    logic [12:0] obs;
    assign obs = {out_valid_o, out_data_o, out_last_o, busy_o, word_len_o, empty_word_o, overrun_o};

    typedef struct {
        logic        fd;
        logic [31:0] w;
        logic        rdy;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fd, input logic [31:0] w, input logic rdy,
                                input logic v, input logic [3:0] d, input logic l, input logic b,
                                input logic [3:0] len, input logic e, input logic o);
        vec_t r;
        r.fd  = fd;
        r.w   = w;
        r.rdy = rdy;
        r.exp = {v, d, l, b, len, e, o};
        return r;
    endfunction

    task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {v,d,l,b,len,e,o}=%h required %h", nm, act, exp);
        end
    endtask

    initial begin
        // Full word, ready held high.
        vecs.push_back(mk(1'b1, 32'h87654321, 1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0));
        for (int n = 2; n <= 7; n++)
            vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 4'(n), 1'b0, 1'b1, 4'd8, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 4'h8, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0));
        // Three-nibble word with ready toggling.
        vecs.push_back(mk(1'b1, 32'hCCCCC5A3, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 4'hA, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0));
        // All-pad word: empty pulse only.
        vecs.push_back(mk(1'b1, 32'hCCCCCCCC, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        // Back-to-back words chained on the last handshake.
        vecs.push_back(mk(1'b1, 32'hCCCCCC21, 1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 4'h2, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 32'hCCCCCC43, 1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 4'h4, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0));
        // Pad value below the highest data slot is real data.
        vecs.push_back(mk(1'b1, 32'hCCCCCC1C, 1'b1, 1'b1, 4'hC, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 4'h1, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0));
        // Strobe while busy: dropped, overrun sticky, drain unaffected.
        vecs.push_back(mk(1'b1, 32'hCCCC4321, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 32'h99999999, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 4'd4, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 4'h2, 1'b0, 1'b1, 4'd4, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 4'd4, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 4'h4, 1'b1, 1'b1, 4'd4, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1));

        reset        = 1'b1;
        flush_word_i = 32'h0;
        flush_done_i = 1'b0;
        out_ready_i  = 1'b0;
        #2 reset = 1'b0;
        #1 check("reset_async", obs, 13'h0);
        @(posedge clk); @(posedge clk); #1;
        check("reset_held", obs, 13'h0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            flush_done_i = vecs[i].fd;
            flush_word_i = vecs[i].w;
            out_ready_i  = vecs[i].rdy;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), obs, vecs[i].exp);
        end

        // Reset mid-drain after two nibbles accepted.
        flush_done_i = 1'b1; flush_word_i = 32'h87654321; out_ready_i = 1'b1;
        @(posedge clk); #1;
        flush_done_i = 1'b0; flush_word_i = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_nib3", obs, {1'b1, 4'h3, 1'b0, 1'b1, 4'd8, 1'b0, 1'b1});
        out_ready_i = 1'b0;
        #1 check("valid_indep_ready", {12'h0, out_valid_o}, 13'h1);
        #1 reset = 1'b0;
        #1 check("midsend_reset", obs, 13'h0);
        @(posedge clk); #1;
        reset = 1'b1; out_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("post_reset_idle%0d", c), obs, 13'h0);
        end
        flush_done_i = 1'b1; flush_word_i = 32'hCCCCCC21;
        @(posedge clk); #1;
        flush_done_i = 1'b0;
        check("post_reset_new", obs, {1'b1, 4'h1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
